// File: rtl/m68k_bus_cycle_pkg.sv
// Shared definitions for the 68000 bus-cycle engine: state encoding,
// transfer size codes, function codes and the latched request record.
package m68k_bus_pkg;

    localparam int ADDR_W = 24;

    // Bus-cycle sequencer states; S0..S7 follow the 68000 bus phases
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARM,
        ST_S0,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_S4,
        ST_S5,
        ST_S6,
        ST_S7,
        ST_GAP
    } bus_state_e;

    // Transfer size codes; code 3 is handled exactly like a word
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_WORD = 2'd1;
    localparam logic [1:0] SZ_LONG = 2'd2;

    // 68000 function codes
    localparam logic [2:0] FC_USER_DATA  = 3'd1;
    localparam logic [2:0] FC_USER_PROG  = 3'd2;
    localparam logic [2:0] FC_SUPER_DATA = 3'd5;
    localparam logic [2:0] FC_SUPER_PROG = 3'd6;
    localparam logic [2:0] FC_CPU_SPACE  = 3'd7;

    // Request captured on an accepted start
    typedef struct packed {
        logic              rw;
        logic [1:0]        size;
        logic [2:0]        fc;
        logic [ADDR_W-1:0] address;
        logic [31:0]       wdata;
    } bus_req_t;

    // Fold one captured bus word into the read result. Bytes are
    // right-justified and zero-extended; a long fills the upper word on
    // its first half and the lower word on its second half.
    function automatic logic [31:0] merge_read(
        input logic [1:0]  size,
        input logic        a0,
        input logic        second_half,
        input logic [31:0] prev,
        input logic [15:0] din
    );
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {24'h0, (a0 ? din[7:0] : din[15:8])};
            SZ_LONG: r = second_half ? {prev[31:16], din} : {din, 16'h0};
            default: r = {16'h0, din};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/m68k_bus_cycle_if.sv
// Request, strobe and Amiga-bus signals between the Pi-side logic and the
// bus-cycle engine. The engine uses the slave view.
interface m68k_bus_cycle_if;
    import m68k_bus_pkg::*;

    logic              mc_clk_rising;
    logic              mc_clk_falling;
    logic              start;
    logic              req_rw;
    logic [1:0]        req_size;
    logic [2:0]        req_fc;
    logic [ADDR_W-1:0] req_address;
    logic [31:0]       req_data_write;
    logic              dtack_n;
    logic              berr_n;
    logic [15:0]       d_in;
    logic [22:0]       a_out;
    logic [15:0]       d_out;
    logic [2:0]        fc_out;
    logic              rw_out;
    logic              abus_drive;
    logic              dbus_drive;
    logic              as_drive;
    logic              uds_drive;
    logic              lds_drive;
    logic [31:0]       data_read;
    logic              active;
    logic              terminated_normally;
    logic              done;

    modport master (
        output mc_clk_rising, mc_clk_falling, start, req_rw, req_size, req_fc,
               req_address, req_data_write, dtack_n, berr_n, d_in,
        input  a_out, d_out, fc_out, rw_out, abus_drive, dbus_drive, as_drive,
               uds_drive, lds_drive, data_read, active, terminated_normally, done
    );

    modport slave (
        input  mc_clk_rising, mc_clk_falling, start, req_rw, req_size, req_fc,
               req_address, req_data_write, dtack_n, berr_n, d_in,
        output a_out, d_out, fc_out, rw_out, abus_drive, dbus_drive, as_drive,
               uds_drive, lds_drive, data_read, active, terminated_normally, done
    );
endinterface

// File: rtl/m68k_bus_cycle_strobe_decode.sv
// Data-strobe enables and outgoing data lane for the current transfer.
// Bytes select UDS (even) or LDS (odd) and are replicated on both lanes;
// words and longs use both strobes, longs sending the high word first.
module m68k_strobe_decode
    import m68k_bus_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        a0_i,
    input  logic        second_half_i,
    input  logic [31:0] wdata_i,
    output logic        uds_en_o,
    output logic        lds_en_o,
    output logic [15:0] d_lane_o
);

    logic [15:0] byte_rep;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_byte_rep
            assign byte_rep[gi*8 +: 8] = wdata_i[7:0];
        end
    endgenerate

    // Select strobes and data lane from size, A0 and which long half is active
    always_comb begin
        uds_en_o = 1'b1;
        lds_en_o = 1'b1;
        d_lane_o = wdata_i[15:0];
        case (size_i)
            SZ_BYTE: begin
                uds_en_o = ~a0_i;
                lds_en_o = a0_i;
                d_lane_o = byte_rep;
            end
            SZ_LONG: d_lane_o = second_half_i ? wdata_i[15:0] : wdata_i[31:16];
            default: ;
        endcase
    end

endmodule

// File: rtl/m68k_bus_cycle.sv
// 68000 bus-cycle engine. Walks S0..S7 on MC_CLK edge strobes, drives the
// bus output enables, collects read data and reports how the cycle ended.
// A long transfer runs as two word cycles with address +2 (24-bit wrap).
module m68k_bus_cycle
    import m68k_bus_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 255
) (
    input  logic            sys_clk,
    input  logic            reset,
    m68k_bus_cycle_if.slave bus
);

    localparam int WAIT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS + 1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT_CLKS);

    bus_state_e         state_q;
    bus_req_t           req_q;
    logic               second_q;
    logic               err_q;
    logic [WAIT_W-1:0]  wait_cnt_q;
    logic [22:0]        a_out_q;
    logic [15:0]        d_out_q;
    logic [2:0]         fc_out_q;
    logic               rw_out_q;
    logic               abus_q;
    logic               dbus_q;
    logic               as_q;
    logic               uds_q;
    logic               lds_q;
    logic [31:0]        data_read_q;
    logic               active_q;
    logic               term_ok_q;
    logic               done_q;

    logic [ADDR_W-1:0]  addr_d;
    logic [WAIT_W-1:0]  wait_cnt_d;
    logic               timeout_hit;
    logic               uds_en;
    logic               lds_en;
    logic [15:0]        d_lane;

    // Second half of a long targets the next word; wraps within 24 bits
    assign addr_d      = second_q ? (req_q.address + ADDR_W'(2)) : req_q.address;
    assign wait_cnt_d  = wait_cnt_q + WAIT_W'(1);
    assign timeout_hit = (TIMEOUT_CLKS != 0) && (wait_cnt_d == TIMEOUT_W);

    m68k_strobe_decode u_strobe (
        .size_i        (req_q.size),
        .a0_i          (req_q.address[0]),
        .second_half_i (second_q),
        .wdata_i       (req_q.wdata),
        .uds_en_o      (uds_en),
        .lds_en_o      (lds_en),
        .d_lane_o      (d_lane)
    );

    // Bus-cycle sequencer with all bus outputs registered
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            second_q    <= 1'b0;
            err_q       <= 1'b0;
            wait_cnt_q  <= '0;
            a_out_q     <= '0;
            d_out_q     <= '0;
            fc_out_q    <= '0;
            rw_out_q    <= 1'b1;
            abus_q      <= 1'b0;
            dbus_q      <= 1'b0;
            as_q        <= 1'b0;
            uds_q       <= 1'b0;
            lds_q       <= 1'b0;
            data_read_q <= '0;
            active_q    <= 1'b0;
            term_ok_q   <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        req_q.rw      <= bus.req_rw;
                        req_q.size    <= bus.req_size;
                        req_q.fc      <= bus.req_fc;
                        req_q.address <= bus.req_address;
                        req_q.wdata   <= bus.req_data_write;
                        second_q      <= 1'b0;
                        err_q         <= 1'b0;
                        active_q      <= 1'b1;
                        state_q       <= ST_ARM;
                    end
                end
                ST_ARM, ST_GAP: begin
                    if (bus.mc_clk_rising) begin
                        abus_q   <= 1'b1;
                        a_out_q  <= addr_d[ADDR_W-1:1];
                        fc_out_q <= req_q.fc;
                        rw_out_q <= req_q.rw;
                        state_q  <= ST_S0;
                    end
                end
                ST_S0: begin
                    if (bus.mc_clk_falling) state_q <= ST_S1;
                end
                ST_S1: begin
                    if (bus.mc_clk_rising) begin
                        as_q       <= 1'b1;
                        wait_cnt_q <= '0;
                        if (req_q.rw) begin
                            uds_q <= uds_en;
                            lds_q <= lds_en;
                        end
                        state_q <= ST_S2;
                    end
                end
                ST_S2: begin
                    if (bus.mc_clk_falling) begin
                        if (!req_q.rw) begin
                            dbus_q  <= 1'b1;
                            d_out_q <= d_lane;
                        end
                        state_q <= ST_S3;
                    end
                end
                ST_S3: begin
                    if (bus.mc_clk_rising) begin
                        if (!req_q.rw) begin
                            uds_q <= uds_en;
                            lds_q <= lds_en;
                        end
                        state_q <= ST_S4;
                    end
                end
                ST_S4: begin
                    if (bus.mc_clk_falling) begin
                        // BERR outranks DTACK; a timeout ends the cycle like BERR
                        if (!bus.berr_n || (bus.dtack_n && timeout_hit)) begin
                            err_q   <= 1'b1;
                            as_q    <= 1'b0;
                            uds_q   <= 1'b0;
                            lds_q   <= 1'b0;
                            state_q <= ST_S7;
                        end else if (!bus.dtack_n) begin
                            state_q <= ST_S5;
                        end else begin
                            wait_cnt_q <= wait_cnt_d;
                        end
                    end
                end
                ST_S5: begin
                    if (bus.mc_clk_rising) state_q <= ST_S6;
                end
                ST_S6: begin
                    if (bus.mc_clk_falling) begin
                        if (req_q.rw) begin
                            data_read_q <= merge_read(req_q.size, req_q.address[0],
                                                      second_q, data_read_q, bus.d_in);
                        end
                        as_q    <= 1'b0;
                        uds_q   <= 1'b0;
                        lds_q   <= 1'b0;
                        state_q <= ST_S7;
                    end
                end
                ST_S7: begin
                    if (bus.mc_clk_rising) begin
                        dbus_q <= 1'b0;
                        if ((req_q.size == SZ_LONG) && !second_q && !err_q) begin
                            // Keep the address bus owned across the two halves
                            second_q <= 1'b1;
                            state_q  <= ST_GAP;
                        end else begin
                            abus_q    <= 1'b0;
                            rw_out_q  <= 1'b1;
                            active_q  <= 1'b0;
                            done_q    <= 1'b1;
                            term_ok_q <= ~err_q;
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.a_out               = a_out_q;
    assign bus.d_out               = d_out_q;
    assign bus.fc_out              = fc_out_q;
    assign bus.rw_out              = rw_out_q;
    assign bus.abus_drive          = abus_q;
    assign bus.dbus_drive          = dbus_q;
    assign bus.as_drive            = as_q;
    assign bus.uds_drive           = uds_q;
    assign bus.lds_drive           = lds_q;
    assign bus.data_read           = data_read_q;
    assign bus.active              = active_q;
    assign bus.terminated_normally = term_ok_q;
    assign bus.done                = done_q;

endmodule

// File: tb/tb_m68k_bus_cycle.sv
// Directed bench for m68k_bus_cycle: MC_CLK strobes every 8 sys_clk
// (rising at phase 0, falling at phase 4) and a simple DTACK/BERR responder.
module tb_m68k_bus_cycle;
    import m68k_bus_pkg::*;

    logic sys_clk = 1'b0;
    logic reset;

    m68k_bus_cycle_if bif();

    m68k_bus_cycle #(.TIMEOUT_CLKS(4)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bif.slave)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Observation state, updated once per sys_clk by the monitor
    int          done_count = 0;
    int          as_count   = 0;
    int          as_cycles  = 0;
    int          fall_cnt   = 0;
    int          mc_cnt     = 0;
    logic        as_prev    = 1'b0;
    logic        uds_seen   = 1'b0;
    logic        lds_seen   = 1'b0;
    logic        dbus_seen  = 1'b0;
    logic [22:0] addr_log [2];
    logic [2:0]  fc_log     = '0;
    logic        rw_log     = 1'b0;
    logic [15:0] dout_log [2];

    // Responder configuration
    logic        dtack_en    = 1'b1;
    logic        berr_en     = 1'b0;
    int          wait_states = 0;
    logic [15:0] read_words [2];

    // Monitor, strobe generator and slave responder in one negedge process
    initial begin
        int half;
        bif.mc_clk_rising  = 1'b0;
        bif.mc_clk_falling = 1'b0;
        bif.dtack_n        = 1'b1;
        bif.berr_n         = 1'b1;
        bif.d_in           = 16'h0;
        forever begin
            @(negedge sys_clk);
            if (bif.done) done_count++;
            if (bif.as_drive) as_cycles++;
            if (bif.as_drive && !as_prev) begin
                if (as_count < 2) addr_log[as_count] = bif.a_out;
                fc_log = bif.fc_out;
                rw_log = bif.rw_out;
                as_count++;
            end
            as_prev = bif.as_drive;
            half = (as_count > 1) ? 1 : 0;
            if (bif.uds_drive) uds_seen = 1'b1;
            if (bif.lds_drive) lds_seen = 1'b1;
            if (bif.dbus_drive) begin
                dbus_seen = 1'b1;
                dout_log[half] = bif.d_out;
            end
            if (!bif.as_drive) fall_cnt = 0;
            else if (bif.mc_clk_falling) fall_cnt++;
            mc_cnt = (mc_cnt + 1) % 8;
            bif.mc_clk_rising  = (mc_cnt == 0);
            bif.mc_clk_falling = (mc_cnt == 4);
            bif.dtack_n = !(bif.as_drive && dtack_en && (fall_cnt >= 1 + wait_states));
            bif.berr_n  = !(bif.as_drive && berr_en && (half == 0) && (fall_cnt >= 1));
            bif.d_in    = bif.as_drive ? read_words[half] : 16'h0;
        end
    end

    task automatic tick;
        @(negedge sys_clk);
        #1;
    endtask

    task automatic clear_monitor;
        done_count = 0; as_count = 0; as_cycles = 0;
        uds_seen = 1'b0; lds_seen = 1'b0; dbus_seen = 1'b0;
        addr_log[0] = '0; addr_log[1] = '0; dout_log[0] = '0; dout_log[1] = '0;
    endtask

    task automatic set_req(input logic rw, input logic [1:0] size, input logic [2:0] fc,
                           input logic [23:0] addr, input logic [31:0] wdata);
        bif.req_rw = rw; bif.req_size = size; bif.req_fc = fc;
        bif.req_address = addr; bif.req_data_write = wdata;
    endtask

    // Issue one request and wait (bounded) for its done pulse, then settle
    task automatic run_cycle(input logic rw, input logic [1:0] size, input logic [2:0] fc,
                             input logic [23:0] addr, input logic [31:0] wdata,
                             output logic timed_out, output logic act1);
        clear_monitor();
        set_req(rw, size, fc, addr, wdata);
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        act1 = bif.active;
        timed_out = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (done_count != 0) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        repeat (40) tick();
    endtask

    task automatic test_reset;
        logic [82:0] obs;
        reset = 1'b1;
        bif.start = 1'b1;
        repeat (3) tick();
        obs = {bif.a_out, bif.d_out, bif.fc_out, bif.rw_out, bif.abus_drive, bif.dbus_drive,
               bif.as_drive, bif.uds_drive, bif.lds_drive, bif.data_read, bif.active,
               bif.terminated_normally, bif.done};
        checks++;
        if (obs !== {23'h0, 16'h0, 3'h0, 1'b1, 5'h0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL reset_values: got %h expected %h", obs,
                               {23'h0, 16'h0, 3'h0, 1'b1, 5'h0, 32'h0, 1'b0, 1'b1, 1'b0});
        end
        reset = 1'b0;
        bif.start = 1'b0;
        repeat (3) tick();
        checks++;
        if (bif.active !== 1'b0) begin
            errors++; $display("FAIL reset_start_ignored: active got %b expected 0", bif.active);
        end
        $display("test_reset: done");
    endtask

    task automatic test_word_read;
        logic to, act1;
        dtack_en = 1'b1; berr_en = 1'b0; wait_states = 0;
        read_words[0] = 16'h1234;
        run_cycle(1'b1, SZ_WORD, FC_SUPER_DATA, 24'h00DFF006, 32'h0, to, act1);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL word_read_timeout: no done pulse"); end
        checks++; if (act1 !== 1'b1) begin errors++; $display("FAIL word_read_active: got %b expected 1", act1); end
        checks++; if (bif.data_read !== 32'h00001234) begin errors++; $display("FAIL word_read_data: got %h expected 00001234", bif.data_read); end
        checks++; if (bif.terminated_normally !== 1'b1) begin errors++; $display("FAIL word_read_term: got %b expected 1", bif.terminated_normally); end
        checks++; if (done_count !== 1) begin errors++; $display("FAIL word_read_done_count: got %0d expected 1", done_count); end
        checks++; if (addr_log[0] !== 23'h6FF803) begin errors++; $display("FAIL word_read_addr: got %h expected 6ff803", addr_log[0]); end
        checks++; if ({fc_log, rw_log} !== {FC_SUPER_DATA, 1'b1}) begin errors++; $display("FAIL word_read_fc_rw: got %h expected b", {fc_log, rw_log}); end
        checks++; if ({uds_seen, lds_seen, dbus_seen} !== 3'b110) begin errors++; $display("FAIL word_read_strobes: got %b expected 110", {uds_seen, lds_seen, dbus_seen}); end
        checks++; if (as_cycles !== 20) begin errors++; $display("FAIL word_read_as_span: got %0d expected 20", as_cycles); end
        checks++; if ({bif.active, bif.abus_drive, bif.rw_out} !== 3'b001) begin errors++; $display("FAIL word_read_release: got %b expected 001", {bif.active, bif.abus_drive, bif.rw_out}); end
        $display("test_word_read: data=%h as_cycles=%0d", bif.data_read, as_cycles);
    endtask

    task automatic test_byte_access;
        logic to, act1;
        run_cycle(1'b0, SZ_BYTE, FC_USER_DATA, 24'h00BFE001, 32'h123456AB, to, act1);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL byte_write_timeout: no done pulse"); end
        checks++; if ({uds_seen, lds_seen} !== 2'b01) begin errors++; $display("FAIL byte_write_strobes: got %b expected 01", {uds_seen, lds_seen}); end
        checks++; if (dout_log[0] !== 16'hABAB) begin errors++; $display("FAIL byte_write_dout: got %h expected abab", dout_log[0]); end
        checks++; if ({addr_log[0], rw_log} !== {23'h5FF000, 1'b0}) begin errors++; $display("FAIL byte_write_addr_rw: got %h expected %h", {addr_log[0], rw_log}, {23'h5FF000, 1'b0}); end
        checks++; if ({bif.terminated_normally, bif.dbus_drive} !== 2'b10) begin errors++; $display("FAIL byte_write_end: got %b expected 10", {bif.terminated_normally, bif.dbus_drive}); end
        $display("test_byte_access: write d_out=%h", dout_log[0]);
        read_words[0] = 16'h5A3C;
        run_cycle(1'b1, SZ_BYTE, FC_USER_DATA, 24'h000100, 32'h0, to, act1);
        checks++; if (bif.data_read !== 32'h0000005A) begin errors++; $display("FAIL byte_read_even: got %h expected 0000005a", bif.data_read); end
        checks++; if ({uds_seen, lds_seen} !== 2'b10) begin errors++; $display("FAIL byte_read_even_strobes: got %b expected 10", {uds_seen, lds_seen}); end
        $display("test_byte_access: even read=%h", bif.data_read);
        run_cycle(1'b1, SZ_BYTE, FC_USER_DATA, 24'h000101, 32'h0, to, act1);
        checks++; if (bif.data_read !== 32'h0000003C) begin errors++; $display("FAIL byte_read_odd: got %h expected 0000003c", bif.data_read); end
        checks++; if ({uds_seen, lds_seen} !== 2'b01) begin errors++; $display("FAIL byte_read_odd_strobes: got %b expected 01", {uds_seen, lds_seen}); end
        $display("test_byte_access: odd read=%h", bif.data_read);
    endtask

    task automatic test_long_read;
        logic to, act1;
        read_words[0] = 16'hCAFE; read_words[1] = 16'hBABE;
        run_cycle(1'b1, SZ_LONG, FC_SUPER_DATA, 24'hFFFFFE, 32'h0, to, act1);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL long_read_timeout: no done pulse"); end
        checks++; if (bif.data_read !== 32'hCAFEBABE) begin errors++; $display("FAIL long_read_data: got %h expected cafebabe", bif.data_read); end
        checks++; if (as_count !== 2) begin errors++; $display("FAIL long_read_as_count: got %0d expected 2", as_count); end
        checks++; if (addr_log[0] !== 23'h7FFFFF) begin errors++; $display("FAIL long_read_addr0: got %h expected 7fffff", addr_log[0]); end
        checks++; if (addr_log[1] !== 23'h000000) begin errors++; $display("FAIL long_read_addr_wrap: got %h expected 000000", addr_log[1]); end
        checks++; if ({bif.terminated_normally, done_count == 1} !== 2'b11) begin errors++; $display("FAIL long_read_end: term %b done_count %0d expected 1 and 1", bif.terminated_normally, done_count); end
        $display("test_long_read: data=%h", bif.data_read);
    endtask

    task automatic test_long_write;
        logic to, act1;
        berr_en = 1'b1;
        run_cycle(1'b0, SZ_LONG, FC_SUPER_DATA, 24'h001000, 32'h11223344, to, act1);
        berr_en = 1'b0;
        checks++; if (bif.terminated_normally !== 1'b0) begin errors++; $display("FAIL long_berr_term: got %b expected 0", bif.terminated_normally); end
        checks++; if (as_count !== 1) begin errors++; $display("FAIL long_berr_as_count: got %0d expected 1", as_count); end
        checks++; if (done_count !== 1) begin errors++; $display("FAIL long_berr_done_count: got %0d expected 1", done_count); end
        checks++; if (dout_log[0] !== 16'h1122) begin errors++; $display("FAIL long_berr_dout: got %h expected 1122", dout_log[0]); end
        checks++; if (as_cycles !== 12) begin errors++; $display("FAIL long_berr_as_span: got %0d expected 12", as_cycles); end
        $display("test_long_write: berr term=%b", bif.terminated_normally);
        run_cycle(1'b0, SZ_LONG, FC_SUPER_DATA, 24'h002000, 32'hDEADBEEF, to, act1);
        checks++; if (bif.terminated_normally !== 1'b1) begin errors++; $display("FAIL long_write_term: got %b expected 1", bif.terminated_normally); end
        checks++; if ({dout_log[0], dout_log[1]} !== 32'hDEADBEEF) begin errors++; $display("FAIL long_write_dout: got %h expected deadbeef", {dout_log[0], dout_log[1]}); end
        checks++; if (addr_log[1] !== 23'h001001) begin errors++; $display("FAIL long_write_addr1: got %h expected 001001", addr_log[1]); end
        $display("test_long_write: normal d_out=%h%h", dout_log[0], dout_log[1]);
    endtask

    task automatic test_timeout;
        logic to, act1;
        dtack_en = 1'b0;
        run_cycle(1'b1, SZ_WORD, FC_USER_DATA, 24'h000200, 32'h0, to, act1);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL timeout_no_done: no done pulse"); end
        checks++; if (bif.terminated_normally !== 1'b0) begin errors++; $display("FAIL timeout_term: got %b expected 0", bif.terminated_normally); end
        checks++; if (as_cycles !== 36) begin errors++; $display("FAIL timeout_as_span: got %0d expected 36", as_cycles); end
        run_cycle(1'b1, SZ_LONG, FC_USER_DATA, 24'h000300, 32'h0, to, act1);
        checks++; if ({as_count, done_count} !== {32'd1, 32'd1}) begin errors++; $display("FAIL timeout_long: as_count %0d done_count %0d expected 1 and 1", as_count, done_count); end
        dtack_en = 1'b1; wait_states = 3;
        read_words[0] = 16'h7E57;
        run_cycle(1'b1, SZ_WORD, FC_USER_DATA, 24'h000400, 32'h0, to, act1);
        wait_states = 0;
        checks++; if (bif.terminated_normally !== 1'b1) begin errors++; $display("FAIL wait3_term: got %b expected 1", bif.terminated_normally); end
        checks++; if (as_cycles !== 44) begin errors++; $display("FAIL wait3_as_span: got %0d expected 44", as_cycles); end
        checks++; if (bif.data_read !== 32'h00007E57) begin errors++; $display("FAIL wait3_data: got %h expected 00007e57", bif.data_read); end
        $display("test_timeout: wait3 as_cycles=%0d", as_cycles);
    endtask

    task automatic test_back_to_back;
        logic to, act1;
        int n;
        clear_monitor();
        read_words[0] = 16'h0F0F;
        set_req(1'b1, SZ_WORD, FC_USER_DATA, 24'h000400, 32'h0);
        bif.start = 1'b1; tick(); bif.start = 1'b0;
        n = 0;
        while (as_cycles < 4 && n < 200) begin tick(); n++; end
        set_req(1'b0, SZ_WORD, FC_USER_PROG, 24'h000800, 32'h5555AAAA);
        bif.start = 1'b1; tick(); bif.start = 1'b0;
        n = 0;
        while (done_count == 0 && n < 1000) begin tick(); n++; end
        repeat (40) tick();
        checks++; if (done_count !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d expected 1", done_count); end
        checks++; if ({as_count, 9'h0, addr_log[0]} !== {32'd1, 32'h00000200}) begin errors++; $display("FAIL b2b_ignored_start: as_count %0d addr %h expected 1 and 000200", as_count, addr_log[0]); end
        checks++; if (bif.data_read !== 32'h00000F0F) begin errors++; $display("FAIL b2b_data: got %h expected 00000f0f", bif.data_read); end
        run_cycle(1'b0, SZ_WORD, FC_USER_PROG, 24'h000800, 32'h5555AAAA, to, act1);
        checks++; if ({addr_log[0], dout_log[0]} !== {23'h000400, 16'hAAAA}) begin errors++; $display("FAIL b2b_next: got %h expected %h", {addr_log[0], dout_log[0]}, {23'h000400, 16'hAAAA}); end
        $display("test_back_to_back: second addr=%h", addr_log[0]);
    endtask

    task automatic test_reset_midcycle;
        int n;
        clear_monitor();
        dtack_en = 1'b0;
        set_req(1'b0, SZ_WORD, FC_USER_DATA, 24'h000600, 32'h0000BEEF);
        bif.start = 1'b1; tick(); bif.start = 1'b0;
        n = 0;
        while (as_cycles < 16 && n < 200) begin tick(); n++; end
        checks++; if (bif.as_drive !== 1'b1) begin errors++; $display("FAIL midreset_setup: as_drive got %b expected 1", bif.as_drive); end
        reset = 1'b1;
        set_req(1'b1, SZ_WORD, FC_USER_DATA, 24'h000700, 32'h0);
        bif.start = 1'b1;
        tick();
        checks++;
        if ({bif.abus_drive, bif.dbus_drive, bif.as_drive, bif.uds_drive, bif.lds_drive, bif.active, bif.done, bif.rw_out} !== 8'b00000001) begin
            errors++; $display("FAIL midreset_release: got %b expected 00000001",
                {bif.abus_drive, bif.dbus_drive, bif.as_drive, bif.uds_drive, bif.lds_drive, bif.active, bif.done, bif.rw_out});
        end
        tick();
        reset = 1'b0;
        bif.start = 1'b0;
        dtack_en = 1'b1;
        repeat (40) tick();
        checks++; if ({bif.active, as_count == 1, done_count == 0} !== 3'b011) begin errors++; $display("FAIL midreset_after: active %b as_count %0d done_count %0d expected 0, 1, 0", bif.active, as_count, done_count); end
        $display("test_reset_midcycle: active=%b", bif.active);
    endtask

    initial begin
        reset = 1'b1;
        bif.start = 1'b0;
        set_req(1'b1, SZ_WORD, 3'd0, 24'h0, 32'h0);
        read_words[0] = 16'h0; read_words[1] = 16'h0;
        addr_log[0] = '0; addr_log[1] = '0; dout_log[0] = '0; dout_log[1] = '0;
        test_reset();
        test_word_read();
        test_byte_access();
        test_long_read();
        test_long_write();
        test_timeout();
        test_back_to_back();
        test_reset_midcycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
